// File: rtl/nios_dbg_pkg.sv
// Shared constants and types for the debug-slave system-clock command path.
//   JDO_FLAG_BIT : offset of the action flag from the top of jdo (flag bit = SR_W - JDO_FLAG_BIT)
//   IR_*         : virtual IR codes selecting OCI memory, trace, break and trace memory
//   dbg_cmd_t    : command record {ir, data} at the default 2/38-bit widths
package nios_dbg_pkg;

  localparam int JDO_FLAG_BIT = 1;

  localparam int IR_OCIMEM   = 0;
  localparam int IR_TRACE    = 1;
  localparam int IR_BREAK    = 2;
  localparam int IR_TRACEMEM = 3;

  localparam int DBG_IR_W = 2;
  localparam int DBG_SR_W = 38;

  typedef struct packed {
    logic [DBG_IR_W-1:0] ir;
    logic [DBG_SR_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/nios_dbg_toggle_sync.sv
// Toggle-to-pulse synchronizer for a tck-domain toggle entering clk.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   tgl_i  : toggle level, asynchronous to clk_i
//   evt_o  : combinational one-cycle event per toggle edge, valid once primed
module nios_dbg_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tgl_i,
  output logic evt_o
);

  localparam int PRIME = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(PRIME + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   primed;

  assign primed = (cnt_q == CNT_W'(PRIME));

  // prev always follows the last stage, so whatever toggle level is present
  // when reset releases becomes the baseline while the counter holds events off.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!primed) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign evt_o = primed && (sync_q[SYNC_STAGES-1] ^ prev_q);

endmodule

// File: rtl/nios_dbg_sysclk_cmdq.sv
// System-clock side of the CPU debug slave. Synchronizes update-DR/update-IR
// toggles from tck, queues {ir, sr} per update-DR in a small FIFO and turns
// each popped command into a one-hot take_action / take_no_action pulse.
//   clk, reset_n            : clock, asynchronous active-low reset
//   udr_tgl, uir_tgl        : tck-domain update toggles
//   sr, ir_in               : tck-domain shift data and IR, stable around udr_tgl edges
//   cmd_ready               : consumer accepts head command
//   ovf_clr                 : clears sticky overflow
//   cmd_valid, cmd_ir, jdo  : head command (zero when empty)
//   take_action/_no_action  : one-cycle one-hot pulse per popped command
//   uir_pulse               : one-cycle pulse per update-IR
//   level, overflow         : occupancy, sticky drop flag
module nios_dbg_sysclk_cmdq
  import nios_dbg_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          udr_tgl,
  input  logic                          uir_tgl,
  input  logic [SR_W-1:0]               sr,
  input  logic [IR_W-1:0]               ir_in,
  input  logic                          cmd_ready,
  input  logic                          ovf_clr,
  output logic                          cmd_valid,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [SR_W-1:0]               jdo,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic                          uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int NACT     = 2 ** IR_W;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int FLAG_IDX = SR_W - JDO_FLAG_BIT;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } cmd_t;

  logic udr_evt, uir_evt;

  nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .tgl_i  (udr_tgl),
    .evt_o  (udr_evt)
  );

  nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .tgl_i  (uir_tgl),
    .evt_o  (uir_evt)
  );

  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [NACT-1:0]  act_q, act_d;
  logic [NACT-1:0]  noact_q, noact_d;
  logic             uir_pulse_q;

  logic empty, full, pop, push, drop;
  cmd_t head;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop   = !empty && cmd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push  = udr_evt && (!full || pop);
    drop  = udr_evt && full && !pop;
    head  = empty ? '0 : mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    act_d   = '0;
    noact_d = '0;
    if (pop) begin
      if (head.data[FLAG_IDX]) act_d   = NACT'(1) << head.ir;
      else                     noact_d = NACT'(1) << head.ir;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      act_q       <= '0;
      noact_q     <= '0;
      uir_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      act_q       <= act_d;
      noact_q     <= noact_d;
      uir_pulse_q <= uir_evt;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ir: ir_in, data: sr};
  end

  assign cmd_valid      = !empty;
  assign cmd_ir         = head.ir;
  assign jdo            = head.data;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign uir_pulse      = uir_pulse_q;
  assign level          = level_q;
  assign overflow       = ovf_q;

endmodule
